// File: rtl/multi_alarm_clock.sv
// 24-hour BCD timekeeper with prescaler, NUM_ALARMS loadable alarms and a
// ring/snooze/stop state machine. Optional define: HOUR12_EN (12-hour display).
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   fast_watch_i       one minute per second when high
//   set_time_i         strobe: load new_time_i into current time
//   set_alarm_i        strobe: load new_time_i into alarm[alarm_sel_i]
//   alarm_sel_i        alarm index for set_alarm_i
//   new_time_i         BCD {ms_hr, ls_hr, ms_min, ls_min}
//   alarm_en_i         per-alarm enable mask
//   snooze_i, stop_i   user strobes while ringing
//   cur_time_o         current time, 24-hour BCD
//   disp_time_o, pm_o  display time and PM flag
//   one_sec_o          one-cycle pulse each second
//   sound_alarm_o      high while ringing
//   ringing_id_o       index of the alarm that fired
//   load_err_o         one-cycle pulse when a load is rejected
module multi_alarm_clock #(
   parameter int NUM_ALARMS  = 4,
   parameter int CLK_PER_SEC = 256,
   parameter int SNOOZE_MIN  = 5,
   parameter int RING_MIN    = 1,
   localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  fast_watch_i,
   input  logic                  set_time_i,
   input  logic                  set_alarm_i,
   input  logic [AW-1:0]         alarm_sel_i,
   input  logic [15:0]           new_time_i,
   input  logic [NUM_ALARMS-1:0] alarm_en_i,
   input  logic                  snooze_i,
   input  logic                  stop_i,
   output logic [15:0]           cur_time_o,
   output logic [15:0]           disp_time_o,
   output logic                  pm_o,
   output logic                  one_sec_o,
   output logic                  sound_alarm_o,
   output logic [AW-1:0]         ringing_id_o,
   output logic                  load_err_o
);

   localparam int PW  = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
   localparam int AW1 = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RING,
      S_SNOOZE
   } state_t;

   function automatic logic bcd_ok(input logic [15:0] t);
      logic [3:0] hr_max;
      hr_max = (t[15:12] == 4'd2) ? 4'd3 : 4'd9;
      return (t[15:12] <= 4'd2) && (t[11:8] <= hr_max) &&
             (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
   endfunction

   function automatic logic [15:0] next_min(input logic [15:0] t);
      logic [3:0] h1, h0, m1, m0;
      {h1, h0, m1, m0} = t;
      if (m0 != 4'd9) begin
         m0 = m0 + 4'd1;
      end else begin
         m0 = 4'd0;
         if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
         end else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
               h1 = 4'd0;
               h0 = 4'd0;
            end else if (h0 == 4'd9) begin
               h1 = h1 + 4'd1;
               h0 = 4'd0;
            end else begin
               h0 = h0 + 4'd1;
            end
         end
      end
      return {h1, h0, m1, m0};
   endfunction

   logic [PW-1:0]   presc_q, presc_d;
   logic [5:0]      sec_q, sec_d;
   logic [15:0]     cur_q, cur_d;
   logic [15:0]     alarm_q [NUM_ALARMS];
   logic            one_sec_q, one_sec_d;
   logic            err_q, err_d;
   logic            tick_q;
   state_t          state_q, state_d;
   logic [3:0]      ring_q, ring_d;
   logic [3:0]      snz_q, snz_d;
   logic [AW-1:0]   id_q, id_d;

   logic wrap, time_ok, sel_ok, ld_time, wr_alarm;
   logic min_tick, tick_go;
   logic match_hit, match_evt, en_cur;
   logic [AW-1:0] match_idx;

   always_comb begin
      wrap     = (presc_q == PW'(CLK_PER_SEC - 1));
      time_ok  = bcd_ok(new_time_i);
      sel_ok   = ({1'b0, alarm_sel_i} < AW1'(NUM_ALARMS));
      ld_time  = set_time_i && time_ok;
      wr_alarm = set_alarm_i && time_ok && sel_ok;
      min_tick = wrap && (fast_watch_i || sec_q == 6'd59);
      // A load in the same cycle swallows the minute tick.
      tick_go  = min_tick && !ld_time;
   end

   always_comb begin
      presc_d   = presc_q + PW'(1);
      sec_d     = sec_q;
      cur_d     = cur_q;
      one_sec_d = wrap && !ld_time;
      err_d     = (set_time_i && !time_ok) ||
                  (set_alarm_i && !(time_ok && sel_ok));
      if (wrap) begin
         presc_d = '0;
         sec_d   = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
      end
      if (fast_watch_i) begin
         sec_d = 6'd0;
      end
      if (tick_go) begin
         cur_d = next_min(cur_q);
      end
      if (ld_time) begin
         presc_d = '0;
         sec_d   = 6'd0;
         cur_d   = new_time_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         presc_q   <= '0;
         sec_q     <= 6'd0;
         cur_q     <= 16'h0000;
         one_sec_q <= 1'b0;
         err_q     <= 1'b0;
         tick_q    <= 1'b0;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            alarm_q[i] <= 16'h0000;
         end
      end else begin
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         cur_q     <= cur_d;
         one_sec_q <= one_sec_d;
         err_q     <= err_d;
         tick_q    <= tick_go;
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (wr_alarm && AW'(i) == alarm_sel_i) begin
               alarm_q[i] <= new_time_i;
            end
         end
      end
   end

   // Descending scan so the lowest matching index is the one kept.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alarm_en_i[i] && alarm_q[i] == cur_q) begin
            match_hit = 1'b1;
            match_idx = AW'(i);
         end
      end
      // Only a tick-driven update may fire; loaded times never do.
      match_evt = tick_q && match_hit;
   end

   always_comb begin
      en_cur = 1'b0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (AW'(i) == id_q) begin
            en_cur = alarm_en_i[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ring_d  = ring_q;
      snz_d   = snz_q;
      id_d    = id_q;
      unique case (state_q)
         S_IDLE: begin
            if (match_evt) begin
               state_d = S_RING;
               id_d    = match_idx;
               ring_d  = 4'(RING_MIN);
            end
         end
         S_RING: begin
            if (!en_cur || stop_i) begin
               state_d = S_IDLE;
            end else if (snooze_i) begin
               state_d = S_SNOOZE;
               snz_d   = 4'(SNOOZE_MIN);
            end else if (tick_go) begin
               ring_d = ring_q - 4'd1;
               if (ring_q <= 4'd1) begin
                  state_d = S_IDLE;
               end
            end
         end
         S_SNOOZE: begin
            if (!en_cur || stop_i) begin
               state_d = S_IDLE;
            end else if (tick_go) begin
               snz_d = snz_q - 4'd1;
               if (snz_q <= 4'd1) begin
                  state_d = S_RING;
                  ring_d  = 4'(RING_MIN);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         ring_q  <= 4'd0;
         snz_q   <= 4'd0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ring_q  <= ring_d;
         snz_q   <= snz_d;
         id_q    <= id_d;
      end
   end

`ifdef HOUR12_EN
   logic [4:0] hr24, hr12;
   always_comb begin
      hr24 = 5'(cur_q[15:12]) * 5'd10 + 5'(cur_q[11:8]);
      if (hr24 == 5'd0) begin
         hr12 = 5'd12;
      end else if (hr24 > 5'd12) begin
         hr12 = hr24 - 5'd12;
      end else begin
         hr12 = hr24;
      end
      if (hr12 >= 5'd10) begin
         disp_time_o = {4'd1, 4'(hr12 - 5'd10), cur_q[7:0]};
      end else begin
         disp_time_o = {4'd0, hr12[3:0], cur_q[7:0]};
      end
      pm_o = (hr24 >= 5'd12);
   end
`else
   assign disp_time_o = cur_q;
   assign pm_o        = 1'b0;
`endif

   assign cur_time_o    = cur_q;
   assign one_sec_o     = one_sec_q;
   assign sound_alarm_o = (state_q == S_RING);
   assign ringing_id_o  = id_q;
   assign load_err_o    = err_q;

endmodule
